// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready request side and a
// valid/ready result side.
//
// Single-cycle operations (ADD, SUB, AND, OR, NOT, XOR, SHL) finish on the
// edge that accepts them. MUL is an unsigned shift-add multiply that takes
// exactly WIDTH extra edges. The block holds at most one operation at a time.
//
// Handshake rules:
//   A request transfers on a rising edge where InValid && InReady.
//   A result is offered while OutValid is high. It is consumed on a rising
//   edge where OutValid && OutReady.
//   Result, flags and OutValid stay stable until that edge.
//   InReady may depend combinationally on OutReady. This lets a new request
//   be accepted on the same edge that retires the held result.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   A, B      in   operands, sampled on accept
//   Opcode    in   operation select, sampled on accept
//   InValid   in   request valid
//   InReady   out  block can accept a request this cycle
//   Result    out  registered result
//   Zero      out  Result == 0
//   Carry     out  unsigned carry / borrow / overflow flag
//   Overflow  out  signed overflow flag
//   Negative  out  Result MSB
//   OutValid  out  Result and flags valid
//   OutReady  in   consumer takes the result this cycle
//   Busy      out  high while the multiply is in progress
//   StateDbg  out  current FSM state (0 IDLE, 1 MUL, 2 DONE)
// ----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Opcode,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Carry,
   output logic             Overflow,
   output logic             Negative,
   output logic             OutValid,
   input  logic             OutReady,
   output logic             Busy,
   output logic [1:0]       StateDbg
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               carry_q;
   logic               ovf_q;
   logic               neg_q;
   logic               out_valid_q;

   // Multiplier datapath: the multiplicand shifts left, the multiplier
   // shifts right, and the accumulator collects the partial products.
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;

   logic               accept;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [2*WIDTH-1:0] acc_d;
   logic               mul_last;

   // rst gates InReady, so reset also wins over a simultaneous accept.
   assign InReady = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && OutReady));
   assign accept  = InValid && InReady;

   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Carry    = carry_q;
   assign Overflow = ovf_q;
   assign Negative = neg_q;
   assign OutValid = out_valid_q;
   assign Busy     = (state_q == S_MUL);
   assign StateDbg = state_q;

   // Single-cycle operation results and flags.
   always_comb begin
      add_sum = {1'b0, A} + {1'b0, B};
      // SUB is A + ~B + 1. The carry out is high when there is no borrow.
      sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (Opcode)
         OP_ADD: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_sum[WIDTH-1:0];
            alu_c   = sub_sum[WIDTH];
            alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_NOT: alu_res = ~A;
         OP_XOR: alu_res = A ^ B;
         OP_SHL: begin
            alu_res = {A[WIDTH-2:0], 1'b0};
            alu_c   = A[WIDTH-1];
            alu_v   = A[WIDTH-1] ^ A[WIDTH-2];
         end
         default: alu_res = '0;  // MUL is handled by the multiplier path
      endcase
   end

   // One shift-add step. The last step's sum is the finished product.
   always_comb begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
      mul_last = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         result_q    <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (Opcode == OP_MUL) begin
                     state_q     <= S_MUL;
                     out_valid_q <= 1'b0;
                     acc_q       <= '0;
                     mcand_q     <= {{WIDTH{1'b0}}, A};
                     mplier_q    <= B;
                     cnt_q       <= '0;
                  end else begin
                     state_q     <= S_DONE;
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     carry_q     <= alu_c;
                     ovf_q       <= alu_v;
                     neg_q       <= alu_res[WIDTH-1];
                     out_valid_q <= 1'b1;
                  end
               end else if ((state_q == S_DONE) && OutReady) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (mul_last) begin
                  state_q     <= S_DONE;
                  result_q    <= acc_d[WIDTH-1:0];
                  zero_q      <= (acc_d[WIDTH-1:0] == '0);
                  carry_q     <= |acc_d[2*WIDTH-1:WIDTH];
                  ovf_q       <= |acc_d[2*WIDTH-1:WIDTH];
                  neg_q       <= acc_d[WIDTH-1];
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu -- directed bench for seq_alu at WIDTH=8.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] A, B;
   logic [2:0]   Opcode;
   logic         InValid, InReady;
   logic [W-1:0] Result;
   logic         Zero, Carry, Overflow, Negative, OutValid, OutReady, Busy;
   logic [1:0]   StateDbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Opcode(Opcode),
      .InValid(InValid), .InReady(InReady), .Result(Result),
      .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .Negative(Negative),
      .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy),
      .StateDbg(StateDbg)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Opcode  = op;
      A       = a;
      B       = b;
      InValid = 1'b1;
   endtask

   task automatic drop();
      InValid = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] res, input logic c,
                          input logic v, input logic n, input logic z);
      chk({tag, ".valid"}, 32'(OutValid), 32'd1);
      chk({tag, ".res"},   32'(Result),   32'(res));
      chk({tag, ".c"},     32'(Carry),    32'(c));
      chk({tag, ".v"},     32'(Overflow), 32'(v));
      chk({tag, ".n"},     32'(Negative), 32'(n));
      chk({tag, ".z"},     32'(Zero),     32'(z));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; A = '0; B = '0; Opcode = 3'b000; InValid = 1'b0; OutReady = 1'b1;
      tick();
      tick();
      // Reset state, with InValid held high to show reset wins.
      issue(OP_ADD, 8'h01, 8'h01);
      #1;
      chk("rst.inready", 32'(InReady),  32'd0);
      chk("rst.valid",   32'(OutValid), 32'd0);
      chk("rst.res",     32'(Result),   32'd0);
      chk("rst.zero",    32'(Zero),     32'd0);
      chk("rst.busy",    32'(Busy),     32'd0);
      chk("rst.state",   32'(StateDbg), 32'd0);
      tick();
      drop();
      chk("rst.noaccept", 32'(OutValid), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle.inready", 32'(InReady), 32'd1);

      // ADD FF+01: wraps to zero with carry.
      issue(OP_ADD, 8'hFF, 8'h01);
      tick();
      drop();
      chk_out("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("add.state", 32'(StateDbg), 32'd2);
      tick();
      chk("add.retire", 32'(OutValid), 32'd0);

      // SUB back-to-back: 80-01 then 01-02.
      issue(OP_SUB, 8'h80, 8'h01);
      tick();
      chk_out("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
      issue(OP_SUB, 8'h01, 8'h02);
      tick();
      chk_out("sub_01_02", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

      // Logic ops, chained with no bubbles.
      issue(OP_AND, 8'hF0, 8'h3C);
      tick();
      chk_out("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(OP_OR, 8'hF0, 8'h0F);
      tick();
      chk_out("or", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(OP_XOR, 8'h55, 8'h55);
      tick();
      chk_out("xor", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHL and signed-overflow ADD.
      issue(OP_SHL, 8'hC0, 8'h00);
      tick();
      chk_out("shl_c0", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
      issue(OP_SHL, 8'h40, 8'h00);
      tick();
      chk_out("shl_40", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
      issue(OP_ADD, 8'h7F, 8'h01);
      tick();
      chk_out("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
      drop();
      tick();

      // MUL 10*11 = 0110. Operands and InValid are toggled while busy.
      issue(OP_MUL, 8'h10, 8'h11);
      tick();
      for (int i = 0; i < 8; i++) begin
         issue(OP_ADD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         #1;
         chk("mul.busy",    32'(Busy),     32'd1);
         chk("mul.inready", 32'(InReady),  32'd0);
         chk("mul.valid",   32'(OutValid), 32'd0);
         tick();
      end
      drop();
      chk_out("mul_10_11", 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mul.done_busy", 32'(Busy), 32'd0);
      tick();

      // Two more products: FF*FF = FE01, 03*05 = 000F.
      issue(OP_MUL, 8'hFF, 8'hFF);
      tick();
      drop();
      for (int i = 0; i < 8; i++) tick();
      chk_out("mul_ff_ff", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      issue(OP_MUL, 8'h03, 8'h05);
      tick();
      drop();
      for (int i = 0; i < 8; i++) tick();
      chk_out("mul_03_05", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Backpressure: the NOT result is held while a waiting ADD is refused.
      OutReady = 1'b0;
      issue(OP_NOT, 8'hA5, 8'h00);
      tick();
      issue(OP_ADD, 8'h01, 8'h01);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_out("hold_not", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("hold.inready", 32'(InReady), 32'd0);
         tick();
      end
      OutReady = 1'b1;
      #1;
      chk("release.inready", 32'(InReady), 32'd1);
      tick();
      drop();
      chk_out("add_after_hold", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Reset on the third MUL cycle aborts the multiply.
      issue(OP_MUL, 8'h10, 8'h11);
      tick();
      drop();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mrst.valid", 32'(OutValid), 32'd0);
      chk("mrst.busy",  32'(Busy),     32'd0);
      chk("mrst.res",   32'(Result),   32'd0);
      chk("mrst.flags", 32'({Zero, Carry, Overflow, Negative}), 32'd0);
      chk("mrst.inready_in_rst", 32'(InReady), 32'd0);
      rst = 1'b0;
      #1;
      chk("mrst.inready", 32'(InReady), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mrst.no_result", 32'(OutValid), 32'd0);
      end

      // Reset while a result is held drops it.
      OutReady = 1'b0;
      issue(OP_ADD, 8'hFF, 8'h01);
      tick();
      drop();
      chk("drst.pre_valid", 32'(OutValid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("drst.valid", 32'(OutValid), 32'd0);
      chk("drst.carry", 32'(Carry),    32'd0);
      chk("drst.state", 32'(StateDbg), 32'd0);
      OutReady = 1'b1;
      tick();

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; legal range 2..32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 A  in  WIDTH  operand A, sampled on accept.
REQ-005 B  in  WIDTH  operand B, sampled on accept.
REQ-006 Opcode  in  3  operation select, sampled on accept.
REQ-007 InValid  in  1  request valid.
REQ-008 InReady  out  1  block can accept a request this cycle.
REQ-009 Result  out  WIDTH  registered result.
REQ-010 Zero  out  1  Result == 0.
REQ-011 Carry  out  1  unsigned carry/borrow/overflow flag, per op.
REQ-012 Overflow  out  1  signed (two's-complement) overflow flag.
REQ-013 Negative  out  1  Result[WIDTH-1].
REQ-014 OutValid  out  1  Result and flags valid.
REQ-015 OutReady  in  1  consumer takes the result this cycle.
REQ-016 Busy  out  1  high while in MUL state.

Function
REQ-017 Accept: a request SHALL be accepted on an edge where InValid && InReady.
REQ-018 FSM states: IDLE, MUL, DONE; reset state IDLE.
REQ-019 InReady SHALL be 1 in IDLE, 1 in DONE when OutReady=1, 0 in MUL, 0 while rst=1.
REQ-020 Opcodes: 000 ADD, 001 SUB (A+~B+1), 010 AND, 011 OR, 100 NOT A, 101 XOR, 110 MUL, 111 SHL (A<<1).
REQ-021 Single-cycle ops (all except MUL): on accept, Result/flags registered, state -> DONE, OutValid=1 on the next cycle (latency 1).
REQ-022 MUL: on accept, state -> MUL; shift-add over exactly WIDTH cycles; then -> DONE; OutValid=1 WIDTH+1 cycles after accept.
REQ-023 ADD: Carry = carry-out of bit WIDTH-1; Overflow = signed overflow.
REQ-024 SUB: Carry = carry-out of A+~B+1 (1 iff A>=B unsigned); Overflow = signed overflow.
REQ-025 AND/OR/NOT/XOR: Carry=0, Overflow=0.
REQ-026 SHL: Result = A<<1 truncated to WIDTH; Carry = A[WIDTH-1]; Overflow = A[WIDTH-1]^A[WIDTH-2].
REQ-027 MUL: unsigned 2*WIDTH product; Result = low WIDTH bits; Carry = Overflow = (high WIDTH bits != 0).
REQ-028 Zero and Negative SHALL be derived from Result for every op.
REQ-029 DONE: Result, flags, OutValid held stable until OutReady=1.
REQ-030 DONE with OutReady=1 and no accept: -> IDLE, OutValid=0 next cycle.
REQ-031 DONE with OutReady=1 and accept in same cycle: new op processed as from IDLE (back-to-back, no bubble for single-cycle ops).
REQ-032 InValid in MUL SHALL be ignored; operands latched at accept, later A/B/Opcode changes have no effect.
REQ-033 Busy = (state == MUL).

Reset
REQ-034 rst=1 at an edge: state IDLE; Result=0, Zero=0, Carry=0, Overflow=0, Negative=0, OutValid=0, Busy=0.
REQ-035 rst during MUL or DONE SHALL abort the operation; no result is ever presented for it.
REQ-036 rst takes priority over accept and OutReady in the same cycle.

Verification (WIDTH=8)
REQ-037 ADD A=FF B=01 -> next cycle OutValid=1, Result=00, Zero=1, Carry=1, Overflow=0, Negative=0.
REQ-038 SUB A=80 B=01 -> Result=7F, Carry=1, Overflow=1, Negative=0; SUB A=01 B=02 -> Result=FF, Carry=0, Negative=1.
REQ-039 MUL A=10 B=11 -> Busy=1 and InReady=0 for 8 cycles, OutValid=1 on 9th cycle after accept, Result=10, Carry=1, Overflow=1.
REQ-040 Backpressure: OutReady=0 for 5 cycles after NOT A=A5 -> Result=5A, Carry=0 held stable, InReady=0; then OutReady=1 with InValid=1 (ADD 01+01) -> accepted, Result=02 next cycle.
REQ-041 rst=1 on 3rd MUL cycle -> next cycle OutValid=0, Busy=0, all outputs 0; InReady=1 first cycle after rst released.
REQ-042 SHL A=C0 -> Result=80, Carry=1, Overflow=0, Negative=1.
